usb_endpoint_pkt: RTL and testbench

- Parametrised next-generation bulk/interrupt endpoint buffer.
- Holds one IN and one OUT transactional FIFO with commit/rollback, plus a per-packet length queue on each direction.
- Tracks the DATA0/DATA1 toggle per direction and generates the handshake response (ACK/NAK, optional STALL) for the protocol engine.
- Sits between the USB protocol engine (PE) and the device-side application logic, all on clk48_i.

---
 rtl/usb_endpoint_pkt.sv | 398 +++++++++++++++++++++++++++++++++++++++
 tb/tb_usb_endpoint_pkt.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_endpoint_pkt.sv
// usb_endpoint_pkt: bulk/interrupt endpoint buffer between the USB protocol
// engine (PE) and the application. It holds one OUT and one IN byte FIFO,
// each with commit/rollback pointers and a per-packet length queue. It also
// tracks the DATA0/DATA1 toggle per direction and produces the handshake
// response for the PE.
//
// Optional feature: define USB_EP_HALT_EN to add the halt_i input (endpoint
// STALL). With the macro undefined there is no halt_i port and STALL is
// never generated.
//
// Ports (all on clk48_i; rst_n_i is an asynchronous, active-low reset):
//   OUT fill (PE side)   : out_fillData_i, out_data_i, out_fillDone_i,
//                          out_fillOk_i, out_pid1_i
//   OUT drain (app side) : out_popData_i, out_dataAvailable_o,
//                          out_isLastPacketByte_o, out_data_o
//   IN fill (app side)   : in_fillData_i, in_data_i, in_fillDone_i, in_full_o
//   IN drain (PE side)   : in_tokenReq_i, in_popData_i, in_data_o,
//                          in_isLastPacketByte_o, in_popDone_i, in_popOk_i
//   Response             : respValid_o, respHandshake_o, respPid1_o
//   Halt (optional)      : halt_i
module usb_endpoint_pkt #(
   parameter int unsigned DATA_WID     = 8,
   parameter int unsigned ADDR_WID     = 9,
   parameter int unsigned PKT_Q_DEPTH  = 4,
   parameter int unsigned MAX_PKT_SIZE = 64
) (
   input  logic                clk48_i,
   input  logic                rst_n_i,
   input  logic                out_fillData_i,
   input  logic [DATA_WID-1:0] out_data_i,
   input  logic                out_fillDone_i,
   input  logic                out_fillOk_i,
   input  logic                out_pid1_i,
   input  logic                out_popData_i,
   output logic                out_dataAvailable_o,
   output logic                out_isLastPacketByte_o,
   output logic [DATA_WID-1:0] out_data_o,
   input  logic                in_fillData_i,
   input  logic [DATA_WID-1:0] in_data_i,
   input  logic                in_fillDone_i,
   output logic                in_full_o,
   input  logic                in_tokenReq_i,
   input  logic                in_popData_i,
   output logic [DATA_WID-1:0] in_data_o,
   output logic                in_isLastPacketByte_o,
   input  logic                in_popDone_i,
   input  logic                in_popOk_i,
   output logic                respValid_o,
   output logic [1:0]          respHandshake_o,
   output logic                respPid1_o
`ifdef USB_EP_HALT_EN
   ,
   input  logic                halt_i
`endif
);

   localparam int unsigned LEN_W = $clog2(MAX_PKT_SIZE + 1);
   localparam int unsigned PQ_W  = (PKT_Q_DEPTH > 1) ? $clog2(PKT_Q_DEPTH) : 1;
   localparam int unsigned PW    = ADDR_WID + 1;
   localparam int unsigned QW    = PQ_W + 1;
   localparam int unsigned DEPTH = 1 << ADDR_WID;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_SIZE);

   typedef enum logic [1:0] {
      HS_ACK   = 2'b00,
      HS_NAK   = 2'b01,
      HS_STALL = 2'b10,
      HS_DATA  = 2'b11
   } hs_e;

   // Full when the wrap bits differ and the index bits match.
   function automatic logic ptr_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
      return (w[PW-1] != r[PW-1]) && (w[PW-2:0] == r[PW-2:0]);
   endfunction

   function automatic logic dq_full(input logic [QW-1:0] t, input logic [QW-1:0] h);
      return (t[QW-1] != h[QW-1]) && (t[QW-2:0] == h[QW-2:0]);
   endfunction

   // ---------------------------------------------------------------- halt
   logic halt_c;
   logic halt_fall_c;
`ifdef USB_EP_HALT_EN
   logic halt_q;
   always_ff @(posedge clk48_i or negedge rst_n_i) begin
      if (!rst_n_i) halt_q <= 1'b0;
      else          halt_q <= halt_i;
   end
   assign halt_c      = halt_i;
   assign halt_fall_c = halt_q & ~halt_i;
`else
   assign halt_c      = 1'b0;
   assign halt_fall_c = 1'b0;
`endif

   // ---------------------------------------------------------------- storage
   logic [DATA_WID-1:0] out_mem [DEPTH];
   logic [DATA_WID-1:0] in_mem  [DEPTH];
   logic [LEN_W-1:0]    out_dq  [PKT_Q_DEPTH];
   logic [LEN_W-1:0]    in_dq   [PKT_Q_DEPTH];

   // ---------------------------------------------------------------- state
   logic [PW-1:0]    out_wr_q, out_wr_d, out_wr_cmt_q, out_wr_cmt_d, out_rd_q, out_rd_d;
   logic [QW-1:0]    out_dt_q, out_dt_d, out_dh_q, out_dh_d;
   logic [LEN_W-1:0] out_len_q, out_len_d, out_rem_q, out_rem_d;
   logic             out_ovf_q, out_ovf_d, out_tog_q, out_tog_d, out_hv_q, out_hv_d;
   logic             out_avail_q, out_avail_d, out_last_q, out_last_d;
   logic [DATA_WID-1:0] out_data_q, out_data_d;

   logic [PW-1:0]    in_wr_q, in_wr_d, in_wr_cmt_q, in_wr_cmt_d;
   logic [PW-1:0]    in_rd_q, in_rd_d, in_rd_cmt_q, in_rd_cmt_d;
   logic [QW-1:0]    in_dt_q, in_dt_d, in_dh_q, in_dh_d;
   logic [LEN_W-1:0] in_len_q, in_len_d, in_cnt_q, in_cnt_d;
   logic             in_ovf_q, in_ovf_d, in_tog_q, in_tog_d;
   logic             in_full_q, in_full_d, in_last_q, in_last_d;
   logic [DATA_WID-1:0] in_data_q, in_data_d;

   logic resp_valid_q, resp_valid_d, resp_pid1_q, resp_pid1_d;
   hs_e  resp_hs_q, resp_hs_d;

   // ---------------------------------------------------------------- OUT fill
   logic             out_wr_en_c, out_push_c, out_resp_c;
   hs_e              out_resp_hs_c;
   logic [LEN_W-1:0] out_pkt_len_c;

   assign out_wr_en_c = out_fillData_i && !ptr_full(out_wr_q, out_rd_q) &&
                        !dq_full(out_dt_q, out_dh_q) && (out_len_q < MAX_LEN);
   assign out_pkt_len_c = out_len_q + LEN_W'(out_wr_en_c);

   // Byte write, then fill-done decides commit / rollback and the handshake.
   always_comb begin
      out_wr_d      = out_wr_q;
      out_wr_cmt_d  = out_wr_cmt_q;
      out_dt_d      = out_dt_q;
      out_len_d     = out_len_q;
      out_ovf_d     = out_ovf_q;
      out_tog_d     = out_tog_q;
      out_push_c    = 1'b0;
      out_resp_c    = 1'b0;
      out_resp_hs_c = HS_ACK;
      if (out_fillData_i) begin
         if (out_wr_en_c) begin
            out_wr_d  = out_wr_q + PW'(1);
            out_len_d = out_len_q + LEN_W'(1);
         end else begin
            out_ovf_d = 1'b1;
         end
      end
      if (out_fillDone_i) begin
         out_len_d = '0;
         out_ovf_d = 1'b0;
         if (halt_c) begin
            out_wr_d      = out_wr_cmt_q;
            out_resp_c    = 1'b1;
            out_resp_hs_c = HS_STALL;
         end else if (!out_fillOk_i) begin
            // Bad CRC: stay silent so the host times out and retries.
            out_wr_d = out_wr_cmt_q;
         end else if (out_ovf_q || (out_fillData_i && !out_wr_en_c) ||
                      dq_full(out_dt_q, out_dh_q)) begin
            out_wr_d      = out_wr_cmt_q;
            out_resp_c    = 1'b1;
            out_resp_hs_c = HS_NAK;
         end else if (out_pid1_i != out_tog_q) begin
            // Retransmission of an already accepted packet: drop, but ACK.
            out_wr_d   = out_wr_cmt_q;
            out_resp_c = 1'b1;
         end else begin
            out_wr_cmt_d = out_wr_d;
            out_push_c   = 1'b1;
            out_dt_d     = out_dt_q + QW'(1);
            out_tog_d    = ~out_tog_q;
            out_resp_c   = 1'b1;
         end
      end
      if (halt_fall_c) out_tog_d = 1'b0;
   end

   // ---------------------------------------------------------------- OUT drain
   logic            out_dq_empty_c;
   logic [ADDR_WID-1:0] out_rd_idx_c;

   assign out_dq_empty_c = (out_dh_q == out_dt_q);
   assign out_rd_idx_c   = out_rd_d[ADDR_WID-1:0];

   // Head descriptor is loaded into out_rem_q; zero-length heads are dropped.
   always_comb begin
      out_rd_d  = out_rd_q;
      out_dh_d  = out_dh_q;
      out_rem_d = out_rem_q;
      out_hv_d  = out_hv_q;
      if (!out_hv_q) begin
         if (!out_dq_empty_c) begin
            out_rem_d = out_dq[out_dh_q[PQ_W-1:0]];
            out_hv_d  = 1'b1;
         end
      end else if (out_rem_q == '0) begin
         out_dh_d = out_dh_q + QW'(1);
         out_hv_d = 1'b0;
      end else if (out_popData_i) begin
         out_rd_d  = out_rd_q + PW'(1);
         out_rem_d = out_rem_q - LEN_W'(1);
         if (out_rem_q == LEN_W'(1)) begin
            out_dh_d = out_dh_q + QW'(1);
            out_hv_d = 1'b0;
         end
      end
      out_avail_d = out_hv_d && (out_rem_d != '0);
      out_last_d  = out_hv_d && (out_rem_d == LEN_W'(1));
      // Prefetch the byte at the next read pointer, bypassing a same-cycle write.
      out_data_d  = (out_wr_en_c && (out_wr_q[ADDR_WID-1:0] == out_rd_idx_c)) ?
                    out_data_i : out_mem[out_rd_idx_c];
   end

   // ---------------------------------------------------------------- IN fill
   logic             in_wr_en_c, in_push_c;
   logic [LEN_W-1:0] in_pkt_len_c;

   // in_full_q always equals the full condition of the current state.
   assign in_wr_en_c   = in_fillData_i && !in_full_q;
   assign in_pkt_len_c = in_len_q + LEN_W'(in_wr_en_c);

   always_comb begin
      in_wr_d     = in_wr_q;
      in_wr_cmt_d = in_wr_cmt_q;
      in_dt_d     = in_dt_q;
      in_len_d    = in_len_q;
      in_ovf_d    = in_ovf_q;
      in_push_c   = 1'b0;
      if (in_fillData_i) begin
         if (in_wr_en_c) begin
            in_wr_d  = in_wr_q + PW'(1);
            in_len_d = in_len_q + LEN_W'(1);
         end else begin
            in_ovf_d = 1'b1;
         end
      end
      if (in_fillDone_i) begin
         in_len_d = '0;
         in_ovf_d = 1'b0;
         if (in_ovf_q || (in_fillData_i && !in_wr_en_c) || dq_full(in_dt_q, in_dh_q)) begin
            in_wr_d = in_wr_cmt_q;
         end else begin
            in_wr_cmt_d = in_wr_d;
            in_push_c   = 1'b1;
            in_dt_d     = in_dt_q + QW'(1);
         end
      end
   end

   // ---------------------------------------------------------------- IN drain
   logic                in_dq_empty_c, in_pop_en_c;
   logic [LEN_W-1:0]    in_head_len_c, in_nh_len_c;
   logic [PQ_W-1:0]     in_nh_idx_c;
   logic [ADDR_WID-1:0] in_rd_idx_c;

   assign in_dq_empty_c = (in_dh_q == in_dt_q);
   assign in_head_len_c = in_dq[in_dh_q[PQ_W-1:0]];
   assign in_pop_en_c   = in_popData_i && !in_dq_empty_c && (in_cnt_q < in_head_len_c);

   // Tentative reads; popDone commits the packet or rewinds for retransmission.
   always_comb begin
      in_rd_d     = in_rd_q;
      in_rd_cmt_d = in_rd_cmt_q;
      in_dh_d     = in_dh_q;
      in_cnt_d    = in_cnt_q;
      in_tog_d    = in_tog_q;
      if (in_pop_en_c) begin
         in_rd_d  = in_rd_q + PW'(1);
         in_cnt_d = in_cnt_q + LEN_W'(1);
      end
      if (in_popDone_i) begin
         in_cnt_d = '0;
         if (in_popOk_i && !in_dq_empty_c) begin
            in_rd_cmt_d = in_rd_d;
            in_dh_d     = in_dh_q + QW'(1);
            if (!halt_c) in_tog_d = ~in_tog_q;
         end else begin
            in_rd_d = in_rd_cmt_q;
         end
      end
      if (halt_fall_c) in_tog_d = 1'b0;
      in_full_d   = ptr_full(in_wr_d, in_rd_cmt_d) || dq_full(in_dt_d, in_dh_d) ||
                    (in_len_d >= MAX_LEN);
      // Next head length; a descriptor pushed this cycle is not yet in in_dq.
      in_nh_idx_c = in_dh_d[PQ_W-1:0];
      in_nh_len_c = (in_push_c && (in_dt_q[PQ_W-1:0] == in_nh_idx_c)) ?
                    in_pkt_len_c : in_dq[in_nh_idx_c];
      in_last_d   = (in_dh_d != in_dt_d) && (in_nh_len_c == in_cnt_d + LEN_W'(1));
      in_rd_idx_c = in_rd_d[ADDR_WID-1:0];
      in_data_d   = (in_wr_en_c && (in_wr_q[ADDR_WID-1:0] == in_rd_idx_c)) ?
                    in_data_i : in_mem[in_rd_idx_c];
   end

   // ---------------------------------------------------------------- response
   // OUT fill-done takes priority over an IN token in the same cycle.
   always_comb begin
      resp_valid_d = 1'b0;
      resp_hs_d    = HS_ACK;
      resp_pid1_d  = 1'b0;
      if (out_fillDone_i) begin
         resp_valid_d = out_resp_c;
         resp_hs_d    = out_resp_hs_c;
      end else if (in_tokenReq_i) begin
         resp_valid_d = 1'b1;
         if (halt_c) begin
            resp_hs_d = HS_STALL;
         end else if (in_dq_empty_c) begin
            resp_hs_d = HS_NAK;
         end else begin
            resp_hs_d   = HS_DATA;
            resp_pid1_d = in_tog_q;
         end
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk48_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         out_wr_q     <= '0;
         out_wr_cmt_q <= '0;
         out_rd_q     <= '0;
         out_dt_q     <= '0;
         out_dh_q     <= '0;
         out_len_q    <= '0;
         out_rem_q    <= '0;
         out_ovf_q    <= 1'b0;
         out_tog_q    <= 1'b0;
         out_hv_q     <= 1'b0;
         out_avail_q  <= 1'b0;
         out_last_q   <= 1'b0;
         in_wr_q      <= '0;
         in_wr_cmt_q  <= '0;
         in_rd_q      <= '0;
         in_rd_cmt_q  <= '0;
         in_dt_q      <= '0;
         in_dh_q      <= '0;
         in_len_q     <= '0;
         in_cnt_q     <= '0;
         in_ovf_q     <= 1'b0;
         in_tog_q     <= 1'b0;
         in_full_q    <= 1'b0;
         in_last_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_hs_q    <= HS_ACK;
         resp_pid1_q  <= 1'b0;
      end else begin
         out_wr_q     <= out_wr_d;
         out_wr_cmt_q <= out_wr_cmt_d;
         out_rd_q     <= out_rd_d;
         out_dt_q     <= out_dt_d;
         out_dh_q     <= out_dh_d;
         out_len_q    <= out_len_d;
         out_rem_q    <= out_rem_d;
         out_ovf_q    <= out_ovf_d;
         out_tog_q    <= out_tog_d;
         out_hv_q     <= out_hv_d;
         out_avail_q  <= out_avail_d;
         out_last_q   <= out_last_d;
         in_wr_q      <= in_wr_d;
         in_wr_cmt_q  <= in_wr_cmt_d;
         in_rd_q      <= in_rd_d;
         in_rd_cmt_q  <= in_rd_cmt_d;
         in_dt_q      <= in_dt_d;
         in_dh_q      <= in_dh_d;
         in_len_q     <= in_len_d;
         in_cnt_q     <= in_cnt_d;
         in_ovf_q     <= in_ovf_d;
         in_tog_q     <= in_tog_d;
         in_full_q    <= in_full_d;
         in_last_q    <= in_last_d;
         resp_valid_q <= resp_valid_d;
         resp_hs_q    <= resp_hs_d;
         resp_pid1_q  <= resp_pid1_d;
      end
   end

   // Storage and data prefetch registers carry no reset.
   always_ff @(posedge clk48_i) begin
      if (out_wr_en_c) out_mem[out_wr_q[ADDR_WID-1:0]] <= out_data_i;
      if (out_push_c)  out_dq[out_dt_q[PQ_W-1:0]]      <= out_pkt_len_c;
      if (in_wr_en_c)  in_mem[in_wr_q[ADDR_WID-1:0]]   <= in_data_i;
      if (in_push_c)   in_dq[in_dt_q[PQ_W-1:0]]        <= in_pkt_len_c;
      out_data_q <= out_data_d;
      in_data_q  <= in_data_d;
   end

   assign out_dataAvailable_o    = out_avail_q;
   assign out_isLastPacketByte_o = out_last_q;
   assign out_data_o             = out_data_q;
   assign in_full_o              = in_full_q;
   assign in_data_o              = in_data_q;
   assign in_isLastPacketByte_o  = in_last_q;
   assign respValid_o            = resp_valid_q;
   assign respHandshake_o        = resp_hs_q;
   assign respPid1_o             = resp_pid1_q;

endmodule

// File: tb/tb_usb_endpoint_pkt.sv
// Self-checking bench for usb_endpoint_pkt: expected handshakes and data bytes
// are queued when stimulus is driven and compared when the DUT produces them.
module tb_usb_endpoint_pkt;

   localparam logic [1:0] ACK = 2'b00, NAK = 2'b01, STALL = 2'b10, DATA = 2'b11;
   localparam int MAX_PKT = 64;
   localparam int PQ_DEPTH = 4;

   logic       clk48_i = 1'b0;
   logic       rst_n_i;
   logic       out_fillData_i, out_fillDone_i, out_fillOk_i, out_pid1_i, out_popData_i;
   logic [7:0] out_data_i;
   logic       out_dataAvailable_o, out_isLastPacketByte_o;
   logic [7:0] out_data_o;
   logic       in_fillData_i, in_fillDone_i, in_full_o;
   logic [7:0] in_data_i;
   logic       in_tokenReq_i, in_popData_i, in_popDone_i, in_popOk_i;
   logic [7:0] in_data_o;
   logic       in_isLastPacketByte_o;
   logic       respValid_o, respPid1_o;
   logic [1:0] respHandshake_o;
`ifdef USB_EP_HALT_EN
   logic       halt_i;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [2:0] resp_q[$];     // {handshake, pid1}
   logic [8:0] out_q[$];      // {last, byte}
   logic [8:0] in_bytes[$];   // {last, byte}
   int         in_lens[$];
   logic       m_out_tog = 1'b0;
   logic       m_in_tog  = 1'b0;
   logic       m_halt    = 1'b0;

   usb_endpoint_pkt dut (
      .clk48_i               (clk48_i),
      .rst_n_i               (rst_n_i),
      .out_fillData_i        (out_fillData_i),
      .out_data_i            (out_data_i),
      .out_fillDone_i        (out_fillDone_i),
      .out_fillOk_i          (out_fillOk_i),
      .out_pid1_i            (out_pid1_i),
      .out_popData_i         (out_popData_i),
      .out_dataAvailable_o   (out_dataAvailable_o),
      .out_isLastPacketByte_o(out_isLastPacketByte_o),
      .out_data_o            (out_data_o),
      .in_fillData_i         (in_fillData_i),
      .in_data_i             (in_data_i),
      .in_fillDone_i         (in_fillDone_i),
      .in_full_o             (in_full_o),
      .in_tokenReq_i         (in_tokenReq_i),
      .in_popData_i          (in_popData_i),
      .in_data_o             (in_data_o),
      .in_isLastPacketByte_o (in_isLastPacketByte_o),
      .in_popDone_i          (in_popDone_i),
      .in_popOk_i            (in_popOk_i),
      .respValid_o           (respValid_o),
      .respHandshake_o       (respHandshake_o),
      .respPid1_o            (respPid1_o)
`ifdef USB_EP_HALT_EN
      ,
      .halt_i                (halt_i)
`endif
   );

   always #10 clk48_i = ~clk48_i;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk48_i);
      #1;
   endtask

   // Every response pulse is matched against the scoreboard.
   always @(negedge clk48_i) begin
      if (rst_n_i === 1'b1 && respValid_o === 1'b1) begin
         if (resp_q.size() == 0) begin
            check_eq("resp_unexpected", 32'(respValid_o), 32'd0);
         end else begin
            logic [2:0] e;
            e = resp_q.pop_front();
            check_eq("resp", 32'({respHandshake_o, respPid1_o}), 32'(e));
         end
      end
   end

   task automatic out_pkt(input int n, input logic [7:0] base, input logic [7:0] step,
                          input logic pid, input logic ok);
      logic exp_valid;
      for (int i = 0; i < n; i++) begin
         out_fillData_i = 1'b1;
         out_data_i     = 8'(base + 8'(i) * step);
         tick();
      end
      out_fillData_i = 1'b0;
      out_fillDone_i = 1'b1;
      out_fillOk_i   = ok;
      out_pid1_i     = pid;
      exp_valid      = 1'b1;
      if (m_halt) begin
         resp_q.push_back({STALL, 1'b0});
      end else if (!ok) begin
         exp_valid = 1'b0;
      end else if (n > MAX_PKT) begin
         resp_q.push_back({NAK, 1'b0});
      end else if (pid != m_out_tog) begin
         resp_q.push_back({ACK, 1'b0});
      end else begin
         resp_q.push_back({ACK, 1'b0});
         for (int i = 0; i < n; i++)
            out_q.push_back({(i == n - 1), 8'(base + 8'(i) * step)});
         m_out_tog = ~m_out_tog;
      end
      tick();
      out_fillDone_i = 1'b0;
      out_fillOk_i   = 1'b0;
      out_pid1_i     = 1'b0;
      check_eq("out_resp_valid", 32'(respValid_o), 32'(exp_valid));
   endtask

   task automatic out_drain(input int n);
      int got = 0;
      int budget = 0;
      while (got < n && budget < 200) begin
         if (out_dataAvailable_o) begin
            logic [8:0] e;
            e = (out_q.size() > 0) ? out_q.pop_front() : 9'h1ff;
            check_eq("out_byte", 32'({out_isLastPacketByte_o, out_data_o}), 32'(e));
            out_popData_i = 1'b1;
            got++;
         end else begin
            out_popData_i = 1'b0;
         end
         tick();
         budget++;
      end
      out_popData_i = 1'b0;
      if (got < n) check_eq("out_drain_timeout", 32'(got), 32'(n));
   endtask

   task automatic in_pkt(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         in_fillData_i = 1'b1;
         in_data_i     = 8'(base + 8'(i));
         tick();
      end
      in_fillData_i = 1'b0;
      in_fillDone_i = 1'b1;
      tick();
      in_fillDone_i = 1'b0;
      if (in_lens.size() < PQ_DEPTH) begin
         for (int i = 0; i < n; i++)
            in_bytes.push_back({(i == n - 1), 8'(base + 8'(i))});
         in_lens.push_back(n);
      end
   endtask

   task automatic in_token();
      in_tokenReq_i = 1'b1;
      if (m_halt)                    resp_q.push_back({STALL, 1'b0});
      else if (in_lens.size() == 0)  resp_q.push_back({NAK, 1'b0});
      else                           resp_q.push_back({DATA, m_in_tog});
      tick();
      in_tokenReq_i = 1'b0;
      check_eq("in_tok_valid", 32'(respValid_o), 32'd1);
   endtask

   task automatic in_pop_pkt(input logic ok);
      int n;
      n = (in_lens.size() > 0) ? in_lens[0] : 0;
      for (int i = 0; i < n; i++) begin
         check_eq("in_byte", 32'({in_isLastPacketByte_o, in_data_o}), 32'(in_bytes[i]));
         in_popData_i = 1'b1;
         tick();
      end
      in_popData_i = 1'b0;
      in_popDone_i = 1'b1;
      in_popOk_i   = ok;
      tick();
      in_popDone_i = 1'b0;
      in_popOk_i   = 1'b0;
      if (ok && in_lens.size() > 0) begin
         for (int i = 0; i < n; i++) void'(in_bytes.pop_front());
         void'(in_lens.pop_front());
         m_in_tog = ~m_in_tog;
      end
   endtask

   initial begin
      rst_n_i = 1'b0;
      out_fillData_i = 1'b0; out_data_i = '0; out_fillDone_i = 1'b0; out_fillOk_i = 1'b0;
      out_pid1_i = 1'b0; out_popData_i = 1'b0;
      in_fillData_i = 1'b0; in_data_i = '0; in_fillDone_i = 1'b0; in_tokenReq_i = 1'b0;
      in_popData_i = 1'b0; in_popDone_i = 1'b0; in_popOk_i = 1'b0;
`ifdef USB_EP_HALT_EN
      halt_i = 1'b0;
`endif
      repeat (3) tick();
      check_eq("rst_out_avail", 32'(out_dataAvailable_o), 32'd0);
      check_eq("rst_out_last", 32'(out_isLastPacketByte_o), 32'd0);
      check_eq("rst_in_full", 32'(in_full_o), 32'd0);
      check_eq("rst_in_last", 32'(in_isLastPacketByte_o), 32'd0);
      check_eq("rst_resp", 32'({respValid_o, respHandshake_o, respPid1_o}), 32'd0);
      rst_n_i = 1'b1;
      tick();

      // Basic DATA0 packet, then its duplicate.
      out_pkt(3, 8'h11, 8'h11, 1'b0, 1'b1);
      out_drain(3);
      check_eq("out_empty_after_drain", 32'(out_dataAvailable_o), 32'd0);
      out_pkt(3, 8'h11, 8'h11, 1'b0, 1'b1);
      repeat (4) tick();
      check_eq("out_dup_no_data", 32'(out_dataAvailable_o), 32'd0);

      // CRC failure between two good packets.
      out_pkt(2, 8'h44, 8'h11, 1'b1, 1'b1);
      out_pkt(3, 8'hEE, 8'h01, 1'b0, 1'b0);
      out_pkt(3, 8'h66, 8'h11, 1'b0, 1'b1);
      out_drain(5);

      // Oversize packet, then a good packet with the same PID.
      out_pkt(MAX_PKT + 1, 8'h00, 8'h01, 1'b1, 1'b1);
      out_pkt(1, 8'h99, 8'h00, 1'b1, 1'b1);
      out_drain(1);

      // Zero-length packet ahead of a data packet.
      out_pkt(0, 8'h00, 8'h00, 1'b0, 1'b1);
      out_pkt(1, 8'h5A, 8'h00, 1'b1, 1'b1);
      out_drain(1);

      // Filling while draining.
      out_pkt(2, 8'h30, 8'h01, m_out_tog, 1'b1);
      fork
         out_drain(2);
         out_pkt(2, 8'h40, 8'h01, m_out_tog, 1'b1);
      join
      out_drain(2);
      check_eq("out_q_left", 32'(out_q.size()), 32'd0);

      // IN: NAK on empty, retransmission on failed delivery, toggle advance.
      in_token();
      in_pkt(4, 8'hC1);
      in_token();
      in_pop_pkt(1'b0);
      in_token();
      in_pop_pkt(1'b1);
      in_token();
      in_pkt(1, 8'hB0);
      in_token();
      in_pop_pkt(1'b1);
      in_pkt(0, 8'h00);
      in_token();
      in_pop_pkt(1'b1);

      // Descriptor queue full.
      for (int i = 0; i < PQ_DEPTH; i++) in_pkt(1, 8'(8'hD0 + 8'(i)));
      check_eq("in_full_set", 32'(in_full_o), 32'(in_lens.size() == PQ_DEPTH));
      in_pkt(1, 8'hFF);
      for (int i = 0; i < PQ_DEPTH; i++) begin
         in_token();
         in_pop_pkt(1'b1);
      end
      check_eq("in_full_clr", 32'(in_full_o), 32'd0);
      in_token();

`ifdef USB_EP_HALT_EN
      if (!m_out_tog) begin
         out_pkt(1, 8'h70, 8'h00, 1'b0, 1'b1);
         out_drain(1);
      end
      if (!m_in_tog) begin
         in_pkt(1, 8'h71);
         in_token();
         in_pop_pkt(1'b1);
      end
      halt_i = 1'b1;
      m_halt = 1'b1;
      tick();
      in_pkt(1, 8'h72);
      in_token();
      out_pkt(1, 8'h73, 8'h00, 1'b1, 1'b1);
      halt_i = 1'b0;
      m_halt = 1'b0;
      m_out_tog = 1'b0;
      m_in_tog = 1'b0;
      tick();
      in_token();
      in_pop_pkt(1'b1);
      out_pkt(1, 8'h74, 8'h00, 1'b0, 1'b1);
      out_drain(1);
`endif

      repeat (4) tick();
      check_eq("resp_pending", 32'(resp_q.size()), 32'd0);
      check_eq("in_model_left", 32'(in_lens.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
